systolic_ctrl: RTL and testbench

SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

---
 rtl/systolic_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_systolic_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/systolic_ctrl.sv
// -----------------------------------------------------------------------------
// systolic_ctrl
//
// Sequencer for an N x N systolic matrix-multiply array. One accepted start
// runs a single pass:
//   IDLE -> CLEAR (1) -> FEED (K+N-1) -> DRAIN (N+2) -> RESULT (N) -> DONE (1)
// During FEED the A/B operand buffers are read at addresses 0..K-1. lane_en
// applies the diagonal input skew so that lane i sees valid operands i cycles
// after lane 0. DRAIN waits for the last partial sums to leave the array.
// RESULT strobes one result row per cycle.
//
// Handshake: start is a level that is sampled only in IDLE. A start with
// k_len=0 is rejected with a one-cycle err pulse. A start seen in any other
// state is ignored. abort is sampled every cycle. In any non-IDLE state it
// returns the FSM to IDLE on the next edge.
//
// Every output comes straight from a flop. The flops are loaded from the
// next-state values, so each output lines up with the state it describes.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   request one matrix pass (sampled in IDLE)
//   k_len      in   inner dimension K, latched on accepted start (>64 -> 64)
//   abort      in   cancel the current pass
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse at the end of a completed pass
//   err        out  one-cycle pulse when a start is rejected (k_len = 0)
//   arr_clr    out  reset for every processing element
//   a_rd_en    out  A operand buffer read strobe
//   b_rd_en    out  B operand buffer read strobe
//   a_rd_addr  out  A operand buffer read address
//   b_rd_addr  out  B operand buffer read address
//   lane_en    out  per-lane operand-valid mask (input skew)
//   res_valid  out  result row capture strobe
//   res_idx    out  index of the result row being captured
//   dbg_state  out  current FSM state encoding, for observation
// -----------------------------------------------------------------------------
module systolic_ctrl #(
    parameter int N      = 4,
    parameter int ADDR_W = 8,
    parameter int KLEN_W = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [KLEN_W-1:0]    k_len,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 arr_clr,
    output logic                 a_rd_en,
    output logic                 b_rd_en,
    output logic [ADDR_W-1:0]    a_rd_addr,
    output logic [ADDR_W-1:0]    b_rd_addr,
    output logic [N-1:0]         lane_en,
    output logic                 res_valid,
    output logic [$clog2(N)-1:0] res_idx,
    output logic [2:0]           dbg_state
);

    // The counter is one bit wider than k_len. K+N-2 therefore fits at
    // K=64, N=16, and the counter never wraps inside a pass.
    localparam int CW    = KLEN_W + 1;
    localparam int IDX_W = $clog2(N);
    localparam int K_MAX = 64;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        FEED   = 3'd2,
        DRAIN  = 3'd3,
        RESULT = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]     cnt_q, cnt_d;   // phase counter: feed t / drain / result row
    logic [CW-1:0]     k_q, k_d;       // latched, saturated inner dimension

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              clr_q, clr_d;
    logic              rd_q, rd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [N-1:0]      lane_q, lane_d;
    logic              rv_q, rv_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    logic [CW-1:0]     k_in;
    logic [CW-1:0]     k_sat;
    logic [CW-1:0]     feed_last;
    logic              feed_d;

    assign k_in      = {1'b0, k_len};
    assign k_sat     = (k_in > CW'(K_MAX)) ? CW'(K_MAX) : k_in;
    assign feed_last = k_q + CW'(N - 2);

    // Next-state and counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        err_d   = 1'b0;
        clr_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (k_len == '0) begin
                        err_d = 1'b1;
                    end else if (abort) begin
                        // The pass is cancelled before it begins. The array
                        // still gets a clear pulse so that it is left clean.
                        clr_d = 1'b1;
                    end else begin
                        k_d     = k_sat;
                        cnt_d   = '0;
                        state_d = CLEAR;
                    end
                end
            end
            CLEAR: begin
                cnt_d   = '0;
                state_d = FEED;
            end
            FEED: begin
                if (cnt_q == feed_last) begin
                    cnt_d   = '0;
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (cnt_q == CW'(N + 1)) begin
                    cnt_d   = '0;
                    state_d = RESULT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESULT: begin
                if (cnt_q == CW'(N - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        // abort wins over every transition out of a busy state.
        if (state_q != IDLE && abort) begin
            cnt_d   = '0;
            state_d = IDLE;
        end
    end

    // Output values that match the state being entered.
    always_comb begin
        feed_d = (state_d == FEED);
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        rd_d   = feed_d && (cnt_d < k_d);
        // The address holds its last value once the read window closes.
        addr_d = rd_d ? ADDR_W'(cnt_d) : addr_q;
        rv_d   = (state_d == RESULT);
        idx_d  = rv_d ? cnt_d[IDX_W-1:0] : '0;
        lane_d = '0;
        for (int i = 0; i < N; i++) begin
            lane_d[i] = feed_d && (cnt_d >= CW'(i)) && ((cnt_d - CW'(i)) < k_d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            k_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            clr_q   <= 1'b1;   // hold the array in reset during rst
            rd_q    <= 1'b0;
            addr_q  <= '0;
            lane_q  <= '0;
            rv_q    <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            clr_q   <= clr_d || (state_d == CLEAR);
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            lane_q  <= lane_d;
            rv_q    <= rv_d;
            idx_q   <= idx_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign arr_clr   = clr_q;
    assign a_rd_en   = rd_q;
    assign b_rd_en   = rd_q;
    assign a_rd_addr = addr_q;
    assign b_rd_addr = addr_q;
    assign lane_en   = lane_q;
    assign res_valid = rv_q;
    assign res_idx   = idx_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_systolic_ctrl.sv
// -----------------------------------------------------------------------------
// tb_systolic_ctrl
//
// Directed bench for systolic_ctrl with N=4, ADDR_W=8, KLEN_W=7. Outputs are
// sampled 1 time unit after each rising edge. "Cycle c" of a pass is the
// cycle that follows the c-th rising edge counted from the accept edge,
// which itself is edge 1. With this numbering CLEAR falls in cycle 1 and
// done falls in cycle K+3N+3.
// -----------------------------------------------------------------------------
module tb_systolic_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [6:0] k_len;
    logic       abort;
    logic       busy, done, err, arr_clr;
    logic       a_rd_en, b_rd_en;
    logic [7:0] a_rd_addr, b_rd_addr;
    logic [3:0] lane_en;
    logic       res_valid;
    logic [1:0] res_idx;
    logic [2:0] dbg_state;

    int checks = 0;
    int errors = 0;

    // Lane masks expected at feed steps t = 0..6 for K=4, N=4.
    logic [3:0] lane_tab [7] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

    systolic_ctrl #(.N(4), .ADDR_W(8), .KLEN_W(7)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .k_len     (k_len),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .arr_clr   (arr_clr),
        .a_rd_en   (a_rd_en),
        .b_rd_en   (b_rd_en),
        .a_rd_addr (a_rd_addr),
        .b_rd_addr (b_rd_addr),
        .lane_en   (lane_en),
        .res_valid (res_valid),
        .res_idx   (res_idx),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ev(input logic b, input logic c, input logic r,
                                       input logic [7:0] ad, input logic [3:0] ln,
                                       input logic rv, input logic [1:0] ix,
                                       input logic dn, input logic er);
        return {3'b0, b, c, r, r, ad, ad, ln, rv, ix, dn, er};
    endfunction

    function automatic logic [31:0] obs_vec();
        return {3'b0, busy, arr_clr, a_rd_en, b_rd_en, a_rd_addr, b_rd_addr,
                lane_en, res_valid, res_idx, done, err};
    endfunction

    // One complete K=4 pass. This task asserts start itself and checks
    // cycles 1..20. It ends in cycle 20 (IDLE) without stepping, so a
    // following call starts a new pass right after DONE. With poke=1, start
    // is held high across edges that fall inside DRAIN.
    task automatic run_k4(input string tag, input logic [7:0] prev_addr, input bit poke);
        logic [31:0] exp;
        start = 1'b1;
        k_len = 7'd4;
        step();
        start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 1)       exp = ev(1, 1, 0, prev_addr, 4'h0, 0, 0, 0, 0);
            else if (c <= 5)  exp = ev(1, 0, 1, 8'(c - 2), lane_tab[c - 2], 0, 0, 0, 0);
            else if (c <= 8)  exp = ev(1, 0, 0, 8'd3, lane_tab[c - 2], 0, 0, 0, 0);
            else if (c <= 14) exp = ev(1, 0, 0, 8'd3, 4'h0, 0, 0, 0, 0);
            else if (c <= 18) exp = ev(1, 0, 0, 8'd3, 4'h0, 1, 2'(c - 15), 0, 0);
            else if (c == 19) exp = ev(1, 0, 0, 8'd3, 4'h0, 0, 0, 1, 0);
            else              exp = ev(0, 0, 0, 8'd3, 4'h0, 0, 0, 0, 0);
            check($sformatf("%s c%0d", tag, c), obs_vec(), exp);
            if (c < 20) begin
                if (poke && c == 10) begin
                    start = 1'b1;
                    k_len = 7'd5;
                end
                if (poke && c == 13) start = 1'b0;
                step();
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        k_len = '0;
        abort = 1'b0;

        // Reset state, with start and abort also driven to show that rst wins.
        start = 1'b1;
        k_len = 7'd4;
        abort = 1'b1;
        step();
        step();
        check("reset outputs", obs_vec(), ev(0, 1, 0, 8'd0, 4'h0, 0, 0, 0, 0));
        check("reset state", 32'(dbg_state), 32'd0);
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b0;
        step();
        check("after release", obs_vec(), ev(0, 0, 0, 8'd0, 4'h0, 0, 0, 0, 0));

        // Basic K=4 pass.
        run_k4("k4", 8'd0, 1'b0);

        // k_len = 0 is rejected with an err pulse.
        start = 1'b1;
        k_len = 7'd0;
        step();
        start = 1'b0;
        check("k0 err", obs_vec(), ev(0, 0, 0, 8'd3, 4'h0, 0, 0, 0, 1));
        step();
        check("k0 after", obs_vec(), ev(0, 0, 0, 8'd3, 4'h0, 0, 0, 0, 0));

        // k_len = 100 saturates to 64: addresses 0..63, done in cycle 79.
        start = 1'b1;
        k_len = 7'd100;
        step();
        start = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            if (c >= 2 && c <= 65)
                check($sformatf("k100 rd c%0d", c), {22'b0, a_rd_en, b_rd_en, a_rd_addr},
                      {22'b0, 1'b1, 1'b1, 8'(c - 2)});
            if (c == 66)
                check("k100 rd off", {19'b0, a_rd_en, b_rd_en, a_rd_addr, lane_en},
                      {19'b0, 1'b0, 1'b0, 8'd63, 4'hE});
            check($sformatf("k100 done c%0d", c), {30'b0, busy, done},
                  {30'b0, (c <= 79), (c == 79)});
            if (c < 80) step();
        end

        // Abort in FEED at t=2 with K=8.
        start = 1'b1;
        k_len = 7'd8;
        step();
        start = 1'b0;
        step();
        step();
        step();
        check("abort t2", obs_vec(), ev(1, 0, 1, 8'd2, 4'h7, 0, 0, 0, 0));
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort idle", obs_vec(), ev(0, 0, 0, 8'd2, 4'h0, 0, 0, 0, 0));
        for (int i = 0; i < 20; i++) begin
            step();
            check($sformatf("abort quiet %0d", i), {30'b0, busy, done}, 32'd0);
        end

        // A full pass after the abort, followed at once by a second pass that
        // pokes start during DRAIN.
        run_k4("post-abort", 8'd2, 1'b0);
        run_k4("drain-poke", 8'd3, 1'b1);

        // Reset asserted in the middle of RESULT.
        start = 1'b1;
        k_len = 7'd4;
        step();
        start = 1'b0;
        for (int c = 1; c < 16; c++) step();
        check("mid-result", obs_vec(), ev(1, 0, 0, 8'd3, 4'h0, 1, 2'd1, 0, 0));
        rst = 1'b1;
        step();
        check("mid-result rst", obs_vec(), ev(0, 1, 0, 8'd0, 4'h0, 0, 0, 0, 0));
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("post-rst %0d", i), obs_vec(), ev(0, 0, 0, 8'd0, 4'h0, 0, 0, 0, 0));
        end

        // abort together with an accepted start: stays IDLE, one arr_clr pulse.
        start = 1'b1;
        k_len = 7'd3;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check("start+abort", obs_vec(), ev(0, 1, 0, 8'd0, 4'h0, 0, 0, 0, 0));
        step();
        check("start+abort after", obs_vec(), ev(0, 0, 0, 8'd0, 4'h0, 0, 0, 0, 0));
        check("start+abort state", 32'(dbg_state), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
